// File: rtl/alu.sv
// RV32I integer ALU for the execute stage.
// Produces a registered result and a registered zero flag one clock after the operands are applied.
module alu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            i_alu_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_c,
   output logic                  o_zero
);

   localparam int SHW = $clog2(DATA_WIDTH);

   typedef enum logic [5:0] {
      OP_NOP   = 6'h00,
      OP_ADD   = 6'h01,
      OP_SUB   = 6'h02,
      OP_AND   = 6'h03,
      OP_OR    = 6'h04,
      OP_XOR   = 6'h05,
      OP_SLT   = 6'h06,
      OP_SLTU  = 6'h07,
      OP_SLL   = 6'h08,
      OP_SRL   = 6'h09,
      OP_SRA   = 6'h0A,
      OP_PASSB = 6'h0B
   } alu_op_e;

   logic [SHW-1:0]        w_shamt;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [DATA_WIDTH-1:0] w_diff;
   logic                  w_slt;
   logic                  w_sltu;
   logic [DATA_WIDTH-1:0] w_sll;
   logic [DATA_WIDTH-1:0] w_srl;
   logic [DATA_WIDTH-1:0] w_sra;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_zero;

   logic [DATA_WIDTH-1:0] r_c;
   logic                  r_zero;

   // Datapath primitives; upper bits of i_b never reach the shifters
   always_comb begin
      w_shamt = i_b[SHW-1:0];
      w_sum   = i_a + i_b;
      w_diff  = i_a - i_b;
      w_slt   = ($signed(i_a) < $signed(i_b));
      w_sltu  = (i_a < i_b);
      w_sll   = i_a << w_shamt;
      w_srl   = i_a >> w_shamt;
      w_sra   = DATA_WIDTH'($signed(i_a) >>> w_shamt);
   end

   // Result select; unassigned encodings behave as NOP
   always_comb begin
      w_result = {DATA_WIDTH{1'b0}};
      case (alu_op_e'(i_alu_op))
         OP_NOP:   w_result = {DATA_WIDTH{1'b0}};
         OP_ADD:   w_result = w_sum;
         OP_SUB:   w_result = w_diff;
         OP_AND:   w_result = i_a & i_b;
         OP_OR:    w_result = i_a | i_b;
         OP_XOR:   w_result = i_a ^ i_b;
         OP_SLT:   w_result = {{(DATA_WIDTH-1){1'b0}}, w_slt};
         OP_SLTU:  w_result = {{(DATA_WIDTH-1){1'b0}}, w_sltu};
         OP_SLL:   w_result = w_sll;
         OP_SRL:   w_result = w_srl;
         OP_SRA:   w_result = w_sra;
         OP_PASSB: w_result = i_b;
         default:  w_result = {DATA_WIDTH{1'b0}};
      endcase
      w_zero = (w_result == {DATA_WIDTH{1'b0}});
   end

   // Output registers; reset wins over any operation in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c    <= {DATA_WIDTH{1'b0}};
         r_zero <= 1'b1;
      end else begin
         r_c    <= w_result;
         r_zero <= w_zero;
      end
   end

   assign o_c    = r_c;
   assign o_zero = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a behavioural model predicts every registered result,
// and directed vectors pin both the model and the DUT to hand-computed values.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [5:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] o_c;
   logic        o_zero;

   int n_checks;
   int n_fail;

   logic [31:0] exp_c;
   logic        exp_valid;

   alu #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_alu_op (op),
      .i_a      (a),
      .i_b      (b),
      .o_c      (o_c),
      .o_zero   (o_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic model using wide integers and division rather than bit operators for shifts
   function automatic logic [31:0] model(input logic [5:0] f_op, input logic [31:0] f_a,
                                         input logic [31:0] f_b);
      longint ua, ub, sa, sb, p, m;
      int     sh;
      ua = longint'(f_a);
      ub = longint'(f_b);
      sa = f_a[31] ? ua - 64'sh1_0000_0000 : ua;
      sb = f_b[31] ? ub - 64'sh1_0000_0000 : ub;
      m  = 64'sh1_0000_0000;
      sh = int'(ub % 64'sd32);
      p  = 64'sd1 << sh;
      case (f_op)
         6'h01: return 32'((ua + ub) % m);
         6'h02: return 32'((ua - ub + m) % m);
         6'h03: return f_a & f_b;
         6'h04: return f_a | f_b;
         6'h05: return f_a ^ f_b;
         6'h06: return (sa < sb) ? 32'd1 : 32'd0;
         6'h07: return (ua < ub) ? 32'd1 : 32'd0;
         6'h08: return 32'((ua * p) % m);
         6'h09: return 32'(ua / p);
         6'h0A: return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 64'sd1) / p));
         6'h0B: return f_b;
         default: return 32'd0;
      endcase
   endfunction

   // Reference pipeline register driven by the model
   always @(posedge clk) begin
      exp_valid <= 1'b1;
      exp_c     <= rst ? 32'd0 : model(op, a, b);
   end

   // Every-cycle comparison of DUT against model
   always @(negedge clk) begin
      if (exp_valid === 1'b1) begin
         n_checks = n_checks + 1;
         if (o_c !== exp_c || o_zero !== (exp_c == 32'd0)) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp t=%0t: got c=%h z=%b, want c=%h z=%b",
                     $time, o_c, o_zero, exp_c, (exp_c == 32'd0));
         end
      end
   end

   // Apply one operation, wait for its result, compare against a hand-computed literal
   task automatic run(input string name, input logic [5:0] t_op, input logic [31:0] t_a,
                      input logic [31:0] t_b, input logic [31:0] lit);
      logic [31:0] m;
      op = t_op;
      a  = t_a;
      b  = t_b;
      m  = model(t_op, t_a, t_b);
      n_checks = n_checks + 1;
      if (!rst && m !== lit) begin
         n_fail = n_fail + 1;
         $display("FAIL %s model: got %h, want %h", name, m, lit);
      end
      @(negedge clk);
      n_checks = n_checks + 1;
      if (o_c !== lit || o_zero !== (lit == 32'd0)) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got c=%h z=%b, want c=%h z=%b", name, o_c, o_zero, lit,
                  (lit == 32'd0));
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      exp_valid = 1'b0;
      exp_c     = 32'd0;
      rst = 1'b1;
      op  = 6'h01;
      a   = 32'd5;
      b   = 32'd7;
      @(negedge clk);
      run("reset_1", 6'h01, 32'd5, 32'd7, 32'd0);
      rst = 1'b0;
      run("add_after_reset", 6'h01, 32'd5, 32'd7, 32'd12);

      run("nop",       6'h00, 32'd1, 32'd1, 32'd0);
      run("add_1_1",   6'h01, 32'd1, 32'd1, 32'h2);
      run("sub_1_1",   6'h02, 32'd1, 32'd1, 32'h0);
      run("sub_0_1",   6'h02, 32'd0, 32'd1, 32'hFFFF_FFFF);
      run("add_wrap",  6'h01, 32'hFFFF_FFFF, 32'd1, 32'h0);
      run("and",       6'h03, 32'h101, 32'h10001, 32'h1);
      run("or",        6'h04, 32'h101, 32'h10001, 32'h10101);
      run("xor",       6'h05, 32'h101, 32'h10001, 32'h10100);
      run("slt_pos",   6'h06, 32'h101, 32'h10001, 32'h1);
      run("slt_neg",   6'h06, 32'h8000_0000, 32'd1, 32'h1);
      run("sltu_neg",  6'h07, 32'h8000_0000, 32'd1, 32'h0);
      run("slt_bound", 6'h06, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);
      run("sltu_bnd",  6'h07, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
      run("slt_eq",    6'h06, 32'h1234_5678, 32'h1234_5678, 32'h0);
      run("sltu_eq",   6'h07, 32'h1234_5678, 32'h1234_5678, 32'h0);
      run("sltu_lt",   6'h07, 32'd1, 32'h8000_0000, 32'h1);
      run("sll",       6'h08, 32'd1, 32'h10, 32'h10000);
      run("srl_1",     6'h09, 32'h100, 32'd1, 32'h80);
      run("srl_31",    6'h09, 32'h8000_0000, 32'd31, 32'h1);
      run("srl_32",    6'h09, 32'h1234, 32'h20, 32'h1234);
      run("sra_3",     6'h0A, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFFE);
      run("sra_31",    6'h0A, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF);
      run("sra_pos",   6'h0A, 32'h4000_0000, 32'd4, 32'h0400_0000);
      run("sll_21",    6'h08, 32'd3, 32'h21, 32'h6);
      run("sll_31",    6'h08, 32'd3, 32'd31, 32'h8000_0000);

      run("b2b_add",   6'h01, 32'd3, 32'd4, 32'h7);
      run("b2b_xor",   6'h05, 32'hF0, 32'hFF, 32'h0F);
      run("b2b_passb", 6'h0B, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run("b2b_op3f",  6'h3F, 32'h1, 32'hDEAD_BEEF, 32'h0);
      run("op_0c",     6'h0C, 32'h5, 32'h6, 32'h0);

      rst = 1'b1;
      run("rst_prio",  6'h01, 32'd1, 32'd1, 32'h0);
      rst = 1'b0;
      run("post_rst",  6'h04, 32'h00F0, 32'h0F00, 32'h0FF0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
